// File: rtl/uart_tx_sched_pkg.sv
// Shared types, widths and helpers for the UART transmit scheduler.
package uart_tx_sched_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned MSG_W       = 32;
    localparam int unsigned LEN_W       = 2;
    localparam int unsigned TIMEOUT_DEF = 2**20;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_GAP
    } state_t;

    // Latched message: up to four bytes plus (byte count - 1)
    typedef struct packed {
        logic [MSG_W-1:0] data;
        logic [LEN_W-1:0] len;
    } msg_t;

    // Counter/index width that never collapses to zero bits
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Byte 0 is the most significant byte of the message word
    function automatic logic [BYTE_W-1:0] msg_byte(input logic [MSG_W-1:0] data,
                                                   input logic [LEN_W-1:0] idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = data[31:24];
            2'd1:    b = data[23:16];
            2'd2:    b = data[15:8];
            default: b = data[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte handshake between the scheduler and the UART transmitter.
//   trmt    : one-cycle start pulse (scheduler -> transmitter)
//   tx_data : byte to send, held until tx_done (scheduler -> transmitter)
//   tx_done : byte finished, pulse or level (transmitter -> scheduler)
interface uart_tx_sched_if;
    import uart_tx_sched_pkg::*;

    logic              trmt;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_done;

    modport master (output trmt, output tx_data, input tx_done);
    modport slave  (input trmt, input tx_data, output tx_done);

endinterface

// File: rtl/uart_tx_sched_rr_arb.sv
// Combinational round-robin picker: searches upward from last_gnt+1 with wrap.
//   req       : request vector
//   last_gnt  : index of the previous winner
//   gnt_c     : one-hot grant (all zero when no request)
//   gnt_idx_c : binary index of the grant
module rr_arb
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    output logic [NUM_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0]   gnt_idx_c
);

    // First requester found at offsets 1..NUM_REQ past the last winner
    always_comb begin : pick
        logic found;
        int   cand;
        gnt_c     = '0;
        gnt_idx_c = '0;
        found     = 1'b0;
        cand      = 0;
        for (int off = 1; off <= int'(NUM_REQ); off++) begin
            cand = int'(last_gnt) + off;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!found && req[i] && (cand == i)) begin
                    found     = 1'b1;
                    gnt_c[i]  = 1'b1;
                    gnt_idx_c = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between message sources.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request level, held until ack
//   msg_data   : NUM_REQ x 32-bit message words (byte 0 = bits [31:24])
//   msg_len    : NUM_REQ x (byte count - 1)
//   ack        : one-cycle pulse, message of requester i latched
//   done       : one-cycle pulse, last byte of requester i completed
//   tx         : trmt/tx_data/tx_done handshake to the UART transmitter
//   busy       : high whenever the FSM is not idle
//   tx_err     : one-cycle pulse when a byte times out
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*MSG_W-1:0] msg_data,
    input  logic [NUM_REQ*LEN_W-1:0] msg_len,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       done,
    uart_tx_sched_if.master          tx,
    output logic                     busy,
    output logic                     tx_err
);

    localparam int unsigned IDX_W = clog2_min1(NUM_REQ);
    localparam int unsigned TO_W  = clog2_min1(TIMEOUT);
    localparam int unsigned GAP_W = clog2_min1(GAP_CYC);
    localparam logic [TO_W-1:0]  TO_TC  = TO_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0] GAP_TC = GAP_W'(GAP_CYC - 1);

    state_t              state_q, state_d;
    msg_t                msg_q, msg_d, req_msg;
    logic [NUM_REQ-1:0]  win_q, win_d;
    logic [IDX_W-1:0]    last_gnt_q, last_gnt_d;
    logic [LEN_W-1:0]    idx_q, idx_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                tx_done_q, tx_done_rise;
    logic [NUM_REQ-1:0]  ack_d, done_d;
    logic                trmt_q, trmt_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                busy_d, tx_err_d;
    logic [NUM_REQ-1:0]  gnt_c;
    logic [IDX_W-1:0]    gnt_idx_c;

    rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req       (req),
        .last_gnt  (last_gnt_q),
        .gnt_c     (gnt_c),
        .gnt_idx_c (gnt_idx_c)
    );

    // Message word and length of the current arbitration winner
    always_comb begin
        req_msg = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_c[i]) begin
                req_msg.data = msg_data[i*MSG_W +: MSG_W];
                req_msg.len  = msg_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Only a fresh rise counts, so a level held across SEND cannot complete the next byte too
    assign tx_done_rise = tx.tx_done & ~tx_done_q;

    // Next state and registered outputs
    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        win_d      = win_q;
        last_gnt_d = last_gnt_q;
        idx_d      = idx_q;
        to_cnt_d   = to_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ack_d      = '0;
        done_d     = '0;
        trmt_d     = 1'b0;
        tx_data_d  = tx_data_q;
        tx_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    msg_d      = req_msg;
                    win_d      = gnt_c;
                    last_gnt_d = gnt_idx_c;
                    idx_d      = '0;
                    to_cnt_d   = '0;
                    ack_d      = gnt_c;
                    trmt_d     = 1'b1;
                    tx_data_d  = msg_byte(req_msg.data, LEN_W'(0));
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: begin
                // Timeout spans the whole byte, counted from the trmt cycle
                if (to_cnt_q != TO_TC) begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_done_rise) begin
                    if (idx_q < msg_q.len) begin
                        idx_d     = idx_q + LEN_W'(1);
                        to_cnt_d  = '0;
                        trmt_d    = 1'b1;
                        tx_data_d = msg_byte(msg_q.data, idx_q + LEN_W'(1));
                        state_d   = ST_SEND;
                    end else begin
                        done_d    = win_q;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                    end
                end else if (to_cnt_q == TO_TC) begin
                    tx_err_d  = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_TC) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, message latch, counters and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            msg_q      <= '0;
            win_q      <= '0;
            last_gnt_q <= IDX_W'(NUM_REQ - 1);
            idx_q      <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            tx_done_q  <= 1'b0;
            ack        <= '0;
            done       <= '0;
            trmt_q     <= 1'b0;
            tx_data_q  <= '0;
            busy       <= 1'b0;
            tx_err     <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_q      <= msg_d;
            win_q      <= win_d;
            last_gnt_q <= last_gnt_d;
            idx_q      <= idx_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_done_q  <= tx.tx_done;
            ack        <= ack_d;
            done       <= done_d;
            trmt_q     <= trmt_d;
            tx_data_q  <= tx_data_d;
            busy       <= busy_d;
            tx_err     <= tx_err_d;
        end
    end

    assign tx.trmt    = trmt_q;
    assign tx.tx_data = tx_data_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NUM_REQ=3, GAP_CYC=4, TIMEOUT=64).
module tb_uart_tx_sched;
    import uart_tx_sched_pkg::*;

    localparam int unsigned NR = 3;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [NR-1:0]       req;
    logic [NR*MSG_W-1:0] msg_data;
    logic [NR*LEN_W-1:0] msg_len;
    logic [NR-1:0]       ack;
    logic [NR-1:0]       done;
    logic                busy;
    logic                tx_err;

    uart_tx_sched_if tx_if();

    uart_tx_sched #(
        .NUM_REQ (NR),
        .GAP_CYC (4),
        .TIMEOUT (64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .msg_data (msg_data),
        .msg_len  (msg_len),
        .ack      (ack),
        .done     (done),
        .tx       (tx_if),
        .busy     (busy),
        .tx_err   (tx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_run = 0;
    int n_fail = 0;
    int trmt_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int ack_log[$];
    int ack_cyc[$];
    int done_cyc[$];
    logic [7:0] byte_log[$];

    // Event log sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_if.trmt) begin
                trmt_cnt++;
                byte_log.push_back(tx_if.tx_data);
            end
            for (int i = 0; i < int'(NR); i++) begin
                if (ack[i]) begin
                    ack_log.push_back(i);
                    ack_cyc.push_back(cyc);
                end
            end
            if (|done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
            if (tx_err) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_trmt(input string tag);
        int n;
        n = 0;
        while (!tx_if.trmt && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(tx_if.trmt), 32'd1);
    endtask

    task automatic finish_byte(input int lat);
        repeat (lat) tick();
        tx_if.tx_done = 1'b1;
        tick();
        tx_if.tx_done = 1'b0;
    endtask

    initial begin
        int c0;
        int t0;
        int d0;
        int e0;
        int a0;
        int n;

        req = '0;
        msg_data = '0;
        msg_len = '0;
        tx_if.tx_done = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_trmt", tx_if.trmt, 0);
        check("rst_data", tx_if.tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_err", tx_err, 0);
        rst_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        // Contention: all three held, one byte each
        msg_data = {32'h3300_0000, 32'h2200_0000, 32'h1100_0000};
        msg_len = '0;
        req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_trmt("cont_trmt");
            if (k == 3) req = '0;
            finish_byte(1);
        end
        check("cont_n", ack_log.size(), 4);
        check("cont_a0", ack_log[0], 0);
        check("cont_a1", ack_log[1], 1);
        check("cont_a2", ack_log[2], 2);
        check("cont_a3", ack_log[3], 0);
        check("cont_b1", byte_log[1], 8'h22);
        check("cont_b2", byte_log[2], 8'h33);
        for (int k = 0; k < 3; k++) begin
            check("cont_gap", ack_cyc[k+1] - done_cyc[k], 5);
        end

        // Pointer rotation: grant 1, then 0 wins over 1
        req = 3'b010;
        wait_trmt("rot1_trmt");
        check("rot1_ack", ack, 3'b010);
        req = '0;
        finish_byte(1);
        req = 3'b011;
        wait_trmt("rot2_trmt");
        check("rot2_ack", ack, 3'b001);
        check("rot2_data", tx_if.tx_data, 8'h11);
        req = '0;
        finish_byte(1);

        // Single requester, three bytes
        msg_data = {32'h0, 32'h0, 32'hAABB_CCDD};
        msg_len = {2'd0, 2'd0, 2'd2};
        req = 3'b001;
        t0 = trmt_cnt;
        d0 = done_cnt;
        a0 = ack_log.size();
        wait_trmt("s_trmt0");
        check("s_ack", ack, 3'b001);
        check("s_b0", tx_if.tx_data, 8'hAA);
        check("s_busy", busy, 1);
        req = '0;
        finish_byte(3);
        check("s_trmt1", tx_if.trmt, 1);
        check("s_b1", tx_if.tx_data, 8'hBB);
        check("s_nodone1", done, 0);
        finish_byte(2);
        check("s_trmt2", tx_if.trmt, 1);
        check("s_b2", tx_if.tx_data, 8'hCC);
        finish_byte(1);
        check("s_done", done, 3'b001);
        check("s_trmt_end", tx_if.trmt, 0);
        tick();
        check("s_done_pulse", done, 0);
        check("s_trmt_cnt", trmt_cnt - t0, 3);
        check("s_done_cnt", done_cnt - d0, 1);
        check("s_ack_cnt", ack_log.size() - a0, 1);

        // Timeout with no tx_done
        repeat (5) tick();
        msg_data = {32'h0, 32'h0, 32'hE100_0000};
        msg_len = '0;
        req = 3'b001;
        wait_trmt("to_trmt");
        c0 = cyc;
        d0 = done_cnt;
        e0 = err_cnt;
        req = '0;
        n = 0;
        while (!tx_err && n < 100) begin
            tick();
            n++;
        end
        check("to_err", tx_err, 1);
        check("to_cycle", cyc - c0, 64);
        check("to_nodone", done, 0);
        check("to_data", tx_if.tx_data, 8'hE1);
        tick();
        tick();
        tick();
        check("to_gap_busy", busy, 1);
        tick();
        check("to_idle", busy, 0);
        check("to_done_cnt", done_cnt - d0, 0);
        check("to_err_cnt", err_cnt - e0, 1);

        // Reset during the second byte's WAIT
        msg_data = {32'h0, 32'h0, 32'h9A8B_0000};
        msg_len = {2'd0, 2'd0, 2'd1};
        req = 3'b001;
        wait_trmt("rm_trmt");
        req = '0;
        d0 = done_cnt;
        finish_byte(1);
        check("rm_b1", tx_if.tx_data, 8'h8B);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("rm_ack", ack, 0);
        check("rm_done", done, 0);
        check("rm_trmt", tx_if.trmt, 0);
        check("rm_data", tx_if.tx_data, 0);
        check("rm_busy", busy, 0);
        check("rm_err", tx_err, 0);
        tick();
        rst_n = 1'b1;
        msg_data = {32'hC300_0000, 32'h0, 32'hA500_0000};
        msg_len = '0;
        req = 3'b101;
        wait_trmt("rm_trmt0");
        check("rm_first", ack, 3'b001);
        check("rm_first_b", tx_if.tx_data, 8'hA5);
        req = 3'b100;
        finish_byte(1);
        wait_trmt("rm_trmt2");
        check("rm_second", ack, 3'b100);
        check("rm_second_b", tx_if.tx_data, 8'hC3);
        req = '0;
        finish_byte(1);
        check("rm_done_cnt", done_cnt - d0, 2);

        // Stray tx_done in IDLE, held tx_done in WAIT, stray in GAP
        repeat (5) tick();
        t0 = trmt_cnt;
        tx_if.tx_done = 1'b1;
        tick();
        tx_if.tx_done = 1'b0;
        tick();
        check("st_idle_trmt", trmt_cnt - t0, 0);
        check("st_idle_busy", busy, 0);
        msg_data = {32'h0, 32'h5A6B_7C00, 32'h0};
        msg_len = {2'd0, 2'd2, 2'd0};
        req = 3'b010;
        wait_trmt("st_trmt0");
        check("st_ack", ack, 3'b010);
        check("st_b0", tx_if.tx_data, 8'h5A);
        req = '0;
        t0 = trmt_cnt;
        tick();
        tx_if.tx_done = 1'b1;
        tick();
        check("st_trmt1", tx_if.trmt, 1);
        check("st_b1", tx_if.tx_data, 8'h6B);
        tick();
        tick();
        tx_if.tx_done = 1'b0;
        tick();
        check("st_hold_cnt", trmt_cnt - t0, 1);
        check("st_hold_data", tx_if.tx_data, 8'h6B);
        check("st_hold_done", done, 0);
        finish_byte(1);
        check("st_trmt2", tx_if.trmt, 1);
        check("st_b2", tx_if.tx_data, 8'h7C);
        finish_byte(1);
        check("st_done", done, 3'b010);
        tick();
        tx_if.tx_done = 1'b1;
        tick();
        tx_if.tx_done = 1'b0;
        tick();
        check("st_gap_cnt", trmt_cnt - t0, 2);
        tick();
        check("st_gap_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
